// File: rtl/miner_pkg.sv
// Shared widths and the queue entry record for the miner datapath.
package miner_pkg;

    localparam int unsigned NONCE_W   = 32;
    localparam int unsigned WORK_ID_W = 4;
    localparam int unsigned DROP_W    = 8;

    // One queued golden ticket: pipeline-corrected nonce plus the work tag it belongs to.
    typedef struct packed {
        logic [NONCE_W-1:0]   nonce;
        logic [WORK_ID_W-1:0] work_id;
    } entry_t;

endpackage

// File: rtl/golden_nonce_queue_if.sv
// Consumer-side handshake of the golden nonce queue (head entry + ready).
interface golden_nonce_queue_if;
    import miner_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    logic [NONCE_W-1:0]   out_nonce;
    logic [WORK_ID_W-1:0] out_work_id;

    modport master (
        output out_valid,
        output out_nonce,
        output out_work_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_nonce,
        input  out_work_id,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Storage, wrapping pointers and level counter for the golden nonce queue.
// The caller only asserts push_i when there is room (or a pop frees a slot this cycle).
module sync_fifo
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  entry_t               push_entry_i,
    output logic [LW-1:0]        level_o,
    golden_nonce_queue_if.master rd
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q,  level_d;
    logic            pop;

    // Head presentation; reset masks the outputs combinationally while it is held.
    assign rd.out_valid   = (level_q != '0) && !rst_i;
    assign rd.out_nonce   = mem[rd_ptr_q].nonce;
    assign rd.out_work_id = mem[rd_ptr_q].work_id;
    assign level_o        = rst_i ? '0 : level_q;
    assign pop            = rd.out_valid && rd.out_ready;

    // Pointer and level next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push_i) level_d = level_q - LW'(1);
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) mem[wr_ptr_q] <= push_entry_i;
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Captures golden tickets, corrects the hasher latency, tags them with the
// current work id, suppresses repeats and queues them for the JTAG side.
module golden_nonce_queue
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic                       new_work,
    input  logic                       golden_valid,
    input  logic [NONCE_W-1:0]         golden_nonce,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NONCE_W-1:0]         out_nonce,
    output logic [WORK_ID_W-1:0]       out_work_id,
    output logic [DROP_W-1:0]          drop_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    golden_nonce_queue_if q_bus ();

    logic [WORK_ID_W-1:0] work_id_q,  work_id_d;
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
    entry_t               last_q,     last_d;
    logic                 last_vld_q, last_vld_d;

    entry_t               cand;
    logic                 is_dup;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic                 drop;
    logic [LW-1:0]        fifo_level;

    assign q_bus.out_ready = out_ready;
    assign out_valid       = q_bus.out_valid;
    assign out_nonce       = q_bus.out_nonce;
    assign out_work_id     = q_bus.out_work_id;
    assign level           = fifo_level;
    assign drop_count      = reset ? '0 : drop_cnt_q;

    // Entry formation, duplicate check and accept/drop decision.
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    always_comb begin
        cand.nonce   = golden_nonce - NONCE_OFFSET;
        cand.work_id = work_id_q;
        is_dup       = last_vld_q && (last_q == cand);
        full         = (fifo_level == LW'(DEPTH));
        pop          = q_bus.out_valid && q_bus.out_ready;
        accept       = golden_valid && !is_dup && !reset && (!full || pop);
        drop         = golden_valid && !is_dup && !reset && full && !pop;
    end

    // Next-state for work tag, drop counter and last-accepted record.
    always_comb begin
        work_id_d  = work_id_q;
        drop_cnt_d = drop_cnt_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (new_work) work_id_d = work_id_q + WORK_ID_W'(1);
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        if (accept) begin
            last_d     = cand;
            last_vld_d = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            work_id_q  <= '0;
            drop_cnt_q <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            work_id_q  <= work_id_d;
            drop_cnt_q <= drop_cnt_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (hash_clk),
        .rst_i        (reset),
        .push_i       (accept),
        .push_entry_i (cand),
        .level_o      (fifo_level),
        .rd           (q_bus)
    );

endmodule
